// File: rtl/systolic_input_skewer.sv
// Input skewer for the PE array: row FIFO, diagonal re-timing (lane i delayed i+1 advances) and tile drain.
// Optional SKEWER_ZERO_FLAG_EN adds a per-lane out_zero flag carried through the skew chains.
module systolic_input_skewer #(
    parameter int WIDTH_B    = 16,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*WIDTH_B-1:0]   in_data,
    input  logic                       in_last,
    input  logic                       array_ready,
    output logic                       pipeline_en,
    output logic [LANES*WIDTH_B-1:0]   out_data,
    output logic [LANES-1:0]           out_valid,
`ifdef SKEWER_ZERO_FLAG_EN
    output logic [LANES-1:0]           out_zero,
`endif
    output logic                       tile_done
);

    localparam int DW    = LANES * WIDTH_B;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DRN_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // FIFO storage: {last, row}
    logic [DW:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [DW:0]        head_entry;

    state_t             state_q, state_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               advance;
    logic               head_valid;
    logic [DW-1:0]      head_data;
    logic               done;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_ready   = ~fifo_full;
    assign push       = in_valid & ~fifo_full;
    assign head_entry = fifo_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // An empty FIFO mid-tile holds the array rather than injecting a bubble,
    // so the diagonal alignment between lanes is never broken.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        pop         = 1'b0;
        advance     = 1'b0;
        head_valid  = 1'b0;
        head_data   = '0;
        done        = 1'b0;
        case (state_q)
            S_IDLE, S_STREAM: begin
                if (!fifo_empty && array_ready) begin
                    pop         = 1'b1;
                    advance     = 1'b1;
                    head_valid  = 1'b1;
                    head_data   = head_entry[DW-1:0];
                    drain_cnt_d = '0;
                    state_d     = head_entry[DW] ? S_DRAIN : S_STREAM;
                end
            end
            S_DRAIN: begin
                if (array_ready) begin
                    advance = 1'b1;
                    if (drain_cnt_q == DRN_W'(LANES - 2)) begin
                        drain_cnt_d = '0;
                        state_d     = S_DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRN_W'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pipeline_en = advance;
    assign tile_done   = done;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [gi:0][WIDTH_B-1:0] data_q, data_d;
        logic [gi:0]              vld_q, vld_d;
`ifdef SKEWER_ZERO_FLAG_EN
        logic [gi:0]              zero_q, zero_d;
`endif

        always_comb begin
            data_d = data_q;
            vld_d  = vld_q;
`ifdef SKEWER_ZERO_FLAG_EN
            zero_d = zero_q;
`endif
            if (advance) begin
                data_d[0] = head_data[gi*WIDTH_B +: WIDTH_B];
                vld_d[0]  = head_valid;
`ifdef SKEWER_ZERO_FLAG_EN
                zero_d[0] = head_valid && (head_data[gi*WIDTH_B +: WIDTH_B] == '0);
`endif
                for (int s = 1; s <= gi; s++) begin
                    data_d[s] = data_q[s-1];
                    vld_d[s]  = vld_q[s-1];
`ifdef SKEWER_ZERO_FLAG_EN
                    zero_d[s] = zero_q[s-1];
`endif
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_q <= '0;
                vld_q  <= '0;
`ifdef SKEWER_ZERO_FLAG_EN
                zero_q <= '0;
`endif
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
`ifdef SKEWER_ZERO_FLAG_EN
                zero_q <= zero_d;
`endif
            end
        end

        assign out_data[gi*WIDTH_B +: WIDTH_B] = data_q[gi];
        assign out_valid[gi]                   = vld_q[gi];
`ifdef SKEWER_ZERO_FLAG_EN
        assign out_zero[gi]                    = zero_q[gi];
`endif
    end

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Self-checking bench for systolic_input_skewer (LANES=4, WIDTH_B=16, FIFO_DEPTH=4).
module tb_systolic_input_skewer;

    localparam int W = 16;
    localparam int L = 4;
    localparam int D = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [L*W-1:0]   in_data;
    logic             in_last;
    logic             array_ready;
    logic             pipeline_en;
    logic [L*W-1:0]   out_data;
    logic [L-1:0]     out_valid;
    logic             tile_done;
`ifdef SKEWER_ZERO_FLAG_EN
    logic [L-1:0]     out_zero;
`endif

    always #5 clk = ~clk;

    systolic_input_skewer #(
        .WIDTH_B    (W),
        .LANES      (L),
        .FIFO_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .array_ready (array_ready),
        .pipeline_en (pipeline_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
`ifdef SKEWER_ZERO_FLAG_EN
        .out_zero    (out_zero),
`endif
        .tile_done   (tile_done)
    );

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        l;
        logic        ar;
        logic        e_rdy;
        logic        e_pe;
        logic [63:0] e_od;
        logic [3:0]  e_ov;
        logic        e_done;
    } vec_t;

    vec_t            vecs [10];
    int              checks = 0;
    int              errors = 0;
    logic [W-1:0]    lane_log [L][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] row_word(input int r, input bit aaaa);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < L; i++) begin
            w[i*W +: W] = aaaa ? 16'hAAAA : 16'(r * 16 + i);
        end
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        array_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst pipeline_en", 64'(pipeline_en), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst tile_done", 64'(tile_done), 64'd0);
`ifdef SKEWER_ZERO_FLAG_EN
        chk("rst out_zero", 64'(out_zero), 64'd0);
`endif
        rst_n = 1'b1;
    endtask

    // Drives one tile with optional initial hold, alternating stall or input gap,
    // logs every valid lane output after each advance, then checks the lane streams.
    task automatic run_tile(input string tag, input int nrows, input bit aaaa, input int hold,
                            input bit stall, input int gap_after, input int gap_len);
        int sent = 0;
        int cyc = 0;
        int adv = 0;
        int dn = 0;
        int gap_cnt = 0;
        bit adv_prev = 1'b0;
        bit in_gap;
        logic [63:0] rw;
        for (int i = 0; i < L; i++) lane_log[i].delete();
        while (dn == 0 && cyc < 300) begin
            @(negedge clk);
            if (adv_prev) begin
                for (int i = 0; i < L; i++) begin
                    if (out_valid[i]) lane_log[i].push_back(out_data[i*W +: W]);
                end
            end
            in_gap      = (gap_len > 0) && (sent == gap_after) && (gap_cnt < gap_len);
            in_valid    = (sent < nrows) && !in_gap;
            in_data     = in_valid ? row_word(sent + 1, aaaa) : '0;
            in_last     = in_valid && (sent == nrows - 1);
            array_ready = (cyc < hold) ? 1'b0 : (stall ? (cyc % 2 == 0) : 1'b1);
            #1;
            if (hold > 0 && cyc <= hold) chk({tag, " in_ready"}, 64'(in_ready), 64'(cyc < D));
            if (!array_ready) chk({tag, " stall pipeline_en"}, 64'(pipeline_en), 64'd0);
            if (in_gap && gap_cnt >= 1 && !stall) chk({tag, " gap pipeline_en"}, 64'(pipeline_en), 64'd0);
            if (in_gap) gap_cnt++;
            if (in_valid && in_ready) sent++;
            adv_prev = pipeline_en;
            if (pipeline_en) adv++;
            if (tile_done) dn++;
            cyc++;
        end
        chk({tag, " tile_done seen"}, 64'(dn), 64'd1);
        @(negedge clk);
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_data     = '0;
        #1;
        chk({tag, " tile_done one cycle"}, 64'(tile_done), 64'd0);
        chk({tag, " advances"}, 64'(adv), 64'(nrows + L - 1));
        for (int i = 0; i < L; i++) begin
            chk({tag, " lane count"}, 64'(lane_log[i].size()), 64'(nrows));
            for (int k = 0; k < nrows && k < lane_log[i].size(); k++) begin
                rw = row_word(k + 1, aaaa);
                chk({tag, " lane data"}, 64'(lane_log[i][k]), 64'(rw[i*W +: W]));
            end
        end
        $display("tile %s: rows=%0d advances=%0d cycles=%0d", tag, nrows, adv, cyc);
    endtask

    initial begin
        logic [63:0] z_row;
        vecs[0] = '{1'b1, 64'h0013_0012_0011_0010, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 4'b0000, 1'b0};
        vecs[1] = '{1'b1, 64'h0023_0022_0021_0020, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 4'b0000, 1'b0};
        vecs[2] = '{1'b1, 64'h0033_0032_0031_0030, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0010, 4'b0001, 1'b0};
        vecs[3] = '{1'b1, 64'h0043_0042_0041_0040, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0011_0020, 4'b0011, 1'b0};
        vecs[4] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0012_0021_0030, 4'b0111, 1'b0};
        vecs[5] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0013_0022_0031_0040, 4'b1111, 1'b0};
        vecs[6] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0023_0032_0041_0000, 4'b1110, 1'b0};
        vecs[7] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0033_0042_0000_0000, 4'b1100, 1'b0};
        vecs[8] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0043_0000_0000_0000, 4'b1000, 1'b1};
        vecs[9] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0043_0000_0000_0000, 4'b1000, 1'b0};

        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid    = vecs[k].v;
            in_data     = vecs[k].d;
            in_last     = vecs[k].l;
            array_ready = vecs[k].ar;
            #1;
            chk("vec in_ready", 64'(in_ready), 64'(vecs[k].e_rdy));
            chk("vec pipeline_en", 64'(pipeline_en), 64'(vecs[k].e_pe));
            chk("vec out_data", out_data, vecs[k].e_od);
            chk("vec out_valid", 64'(out_valid), 64'(vecs[k].e_ov));
            chk("vec tile_done", 64'(tile_done), 64'(vecs[k].e_done));
            $display("vec %0d: pe=%b out_valid=%b out_data=%h tile_done=%b",
                     k, pipeline_en, out_valid, out_data, tile_done);
        end

        do_reset();
        run_tile("fifo_full", 5, 1'b0, 5, 1'b0, 0, 0);
        do_reset();
        run_tile("stall", 4, 1'b0, 0, 1'b1, 0, 0);
        do_reset();
        run_tile("gap", 4, 1'b0, 0, 1'b0, 2, 3);
        do_reset();
        run_tile("single", 1, 1'b1, 0, 1'b0, 0, 0);

        // Reset while draining a single-row tile with zero-valued lanes 0 and 2.
        do_reset();
        z_row = 64'h0007_0000_0005_0000;
        @(negedge clk);
        in_valid = 1'b1; in_data = z_row; in_last = 1'b1; array_ready = 1'b1;
        #1;
        chk("rd pe before pop", 64'(pipeline_en), 64'd0);
        @(negedge clk);
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        #1;
        chk("rd pe pop", 64'(pipeline_en), 64'd1);
        @(negedge clk);
        #1;
        chk("rd pe drain", 64'(pipeline_en), 64'd1);
        chk("rd out_valid lane0", 64'(out_valid), 64'b0001);
        chk("rd out_data lane0", out_data, 64'h0);
`ifdef SKEWER_ZERO_FLAG_EN
        chk("rd out_zero valid zero", 64'(out_zero), 64'b0001);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rd out_valid lane1", 64'(out_valid), 64'b0010);
        chk("rd out_data lane1", out_data, 64'h0000_0000_0005_0000);
`ifdef SKEWER_ZERO_FLAG_EN
        chk("rd out_zero invalid", 64'(out_zero), 64'b0000);
`endif
        @(negedge clk);
        #1;
        chk("rd post out_data", out_data, 64'h0);
        chk("rd post out_valid", 64'(out_valid), 64'd0);
        chk("rd post pipeline_en", 64'(pipeline_en), 64'd0);
        chk("rd post in_ready", 64'(in_ready), 64'd1);
        chk("rd post tile_done", 64'(tile_done), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("rd no tile_done", 64'(tile_done), 64'd0);
        end
        $display("reset during drain: done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
